// File: rtl/joycon_pkg.sv
// Shared types and constants for the Joycon poll scheduler: FSM states, merged key layout, miss counter width.
package joycon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_L  = 3'd1,
    ST_WAIT_L = 3'd2,
    ST_REQ_R  = 3'd3,
    ST_WAIT_R = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam int unsigned MISS_W = 4;
  localparam int unsigned KEYS_W = 22;

  localparam int unsigned KB_L13  = 21;
  localparam int unsigned KB_R12  = 20;
  localparam int unsigned KB_L11  = 19;
  localparam int unsigned KB_R10  = 18;
  localparam int unsigned KB_R9   = 17;
  localparam int unsigned KB_L8   = 16;
  localparam int unsigned KB_L_LO = 8;
  localparam int unsigned KB_R_LO = 0;

  function automatic logic [KEYS_W-1:0] merge_keys(input logic [15:0] kl, input logic [15:0] kr);
    logic [KEYS_W-1:0] k;
    k                 = {KEYS_W{1'b0}};
    k[KB_L13]         = kl[13];
    k[KB_R12]         = kr[12];
    k[KB_L11]         = kl[11];
    k[KB_R10]         = kr[10];
    k[KB_R9]          = kr[9];
    k[KB_L8]          = kl[8];
    k[KB_L_LO +: 8]   = kl[7:0];
    k[KB_R_LO +: 8]   = kr[7:0];
    return k;
  endfunction

  function automatic logic [MISS_W-1:0] miss_sat_inc(input logic [MISS_W-1:0] miss,
                                                     input logic [MISS_W-1:0] limit);
    logic [MISS_W-1:0] res;
    if (miss >= limit) begin
      res = limit;
    end else begin
      res = miss + {{(MISS_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/joycon_tick_gen.sv
// Poll period tick generator: one-cycle registered tick every PERIOD_CYC cycles while enable is high.
module joycon_tick_gen #(
  parameter int unsigned PERIOD_CYC = 750000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int unsigned CNT_W = (PERIOD_CYC > 32'd1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 32'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             at_end_s;

  assign at_end_s = (cnt_q == CNT_LAST);
  assign tick     = tick_q;

  // next count: held at zero while disabled, wraps at the period end
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = enable & at_end_s;
    if (!enable) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (at_end_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // counter and tick registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/joycon_poll_sched.sv
// Joycon poll scheduler: periodic left-then-right poll rounds with timeout, miss tracking and merged key word.
// Optional macro JOYCON_REPROBE_THROTTLE_EN: a disconnected side is only re-probed every 8th round.
module joycon_poll_sched
  import joycon_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned POLL_PERIOD_US = 15000,
  parameter int unsigned TIMEOUT_US     = 5000,
  parameter int unsigned MISS_LIMIT     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        req_L,
  output logic        req_R,
  input  logic        done_L,
  input  logic        done_R,
  input  logic [15:0] keys_L,
  input  logic [15:0] keys_R,
  output logic        conn_L,
  output logic        conn_R,
  output logic [21:0] keys,
  output logic        keys_valid,
  output logic        busy,
  output logic        overrun
);
  localparam int unsigned CYC_PER_US  = CLK_FREQ_HZ / 32'd1_000_000;
  localparam int unsigned PERIOD_CYC  = CYC_PER_US * POLL_PERIOD_US;
  localparam int unsigned TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
  localparam int unsigned WAIT_W      = $clog2(TIMEOUT_CYC + 32'd1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 32'd1);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [MISS_W-1:0]   miss_l_q, miss_l_d, miss_r_q, miss_r_d;
  logic                conn_l_q, conn_l_d, conn_r_q, conn_r_d;
  logic [15:0]         kl_q, kl_d, kr_q, kr_d;
  logic [KEYS_W-1:0]   keys_q, keys_d;
  logic                keys_valid_q, keys_valid_d;
  logic                req_l_q, req_l_d, req_r_q, req_r_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  logic                tick_s, timeout_s, poll_l_s, poll_r_s;
  logic [MISS_W-1:0]   miss_l_inc_s, miss_r_inc_s;

  joycon_tick_gen #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick_s)
  );

`ifdef JOYCON_REPROBE_THROTTLE_EN
  logic [2:0] round_q, round_d;
  assign poll_l_s = conn_l_q | (round_q == 3'd0);
  assign poll_r_s = conn_r_q | (round_q == 3'd0);
  assign round_d  = (state_q == ST_DONE) ? (round_q + 3'd1) : round_q;

  // round counter that gates re-probing of disconnected sides
  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= 3'd0;
    end else begin
      round_q <= round_d;
    end
  end
`else
  assign poll_l_s = 1'b1;
  assign poll_r_s = 1'b1;
`endif

  assign timeout_s    = (wait_q == WAIT_LAST);
  assign miss_l_inc_s = miss_sat_inc(miss_l_q, MISS_MAX);
  assign miss_r_inc_s = miss_sat_inc(miss_r_q, MISS_MAX);

  // round sequencing, response capture and miss bookkeeping
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    miss_l_d  = miss_l_q;
    miss_r_d  = miss_r_q;
    conn_l_d  = conn_l_q;
    conn_r_d  = conn_r_q;
    kl_d      = kl_q;
    kr_d      = kr_q;
    overrun_d = overrun_q | (tick_s & (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        if (tick_s) begin
          if (poll_l_s) begin
            state_d = ST_REQ_L;
          end else if (poll_r_s) begin
            state_d = ST_REQ_R;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ_L: begin
        state_d = ST_WAIT_L;
        wait_d  = {WAIT_W{1'b0}};
      end
      ST_WAIT_L: begin
        // a response in the timeout cycle still counts as a response
        if (done_L) begin
          kl_d     = keys_L;
          miss_l_d = {MISS_W{1'b0}};
          conn_l_d = 1'b1;
          state_d  = poll_r_s ? ST_REQ_R : ST_DONE;
        end else if (timeout_s) begin
          miss_l_d = miss_l_inc_s;
          if (miss_l_inc_s == MISS_MAX) begin
            conn_l_d = 1'b0;
            kl_d     = 16'h0000;
          end else begin
            conn_l_d = conn_l_q;
          end
          state_d = poll_r_s ? ST_REQ_R : ST_DONE;
        end else begin
          wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_REQ_R: begin
        state_d = ST_WAIT_R;
        wait_d  = {WAIT_W{1'b0}};
      end
      ST_WAIT_R: begin
        if (done_R) begin
          kr_d     = keys_R;
          miss_r_d = {MISS_W{1'b0}};
          conn_r_d = 1'b1;
          state_d  = ST_DONE;
        end else if (timeout_s) begin
          miss_r_d = miss_r_inc_s;
          if (miss_r_inc_s == MISS_MAX) begin
            conn_r_d = 1'b0;
            kr_d     = 16'h0000;
          end else begin
            conn_r_d = conn_r_q;
          end
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_l_d      = (state_d == ST_REQ_L);
    req_r_d      = (state_d == ST_REQ_R);
    busy_d       = (state_d != ST_IDLE);
    keys_valid_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      keys_d = merge_keys(kl_d, kr_d);
    end else begin
      keys_d = keys_q;
    end
  end

  // scheduler state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wait_q       <= {WAIT_W{1'b0}};
      miss_l_q     <= {MISS_W{1'b0}};
      miss_r_q     <= {MISS_W{1'b0}};
      conn_l_q     <= 1'b0;
      conn_r_q     <= 1'b0;
      kl_q         <= 16'h0000;
      kr_q         <= 16'h0000;
      keys_q       <= {KEYS_W{1'b0}};
      keys_valid_q <= 1'b0;
      req_l_q      <= 1'b0;
      req_r_q      <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      miss_l_q     <= miss_l_d;
      miss_r_q     <= miss_r_d;
      conn_l_q     <= conn_l_d;
      conn_r_q     <= conn_r_d;
      kl_q         <= kl_d;
      kr_q         <= kr_d;
      keys_q       <= keys_d;
      keys_valid_q <= keys_valid_d;
      req_l_q      <= req_l_d;
      req_r_q      <= req_r_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign req_L      = req_l_q;
  assign req_R      = req_r_q;
  assign conn_L     = conn_l_q;
  assign conn_R     = conn_r_q;
  assign keys       = keys_q;
  assign keys_valid = keys_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_joycon_poll_sched.sv
// Self-checking bench: randomized engine responses checked against a per-side transaction model.
module tb_joycon_poll_sched;
  localparam int TO    = 20;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, done_l, done_r;
  logic [15:0] keys_l, keys_r;
  logic        req_l, req_r, conn_l, conn_r, keys_valid, busy, overrun;
  logic [21:0] keys;

  logic        s_en, s_done_l, s_done_r;
  logic [15:0] s_keys_l, s_keys_r;
  logic        s_req_l, s_req_r, s_conn_l, s_conn_r, s_keys_valid, s_busy, s_overrun;
  logic [21:0] s_keys;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int exp_tl  = 0;

  int          m_miss [2];
  bit          m_conn [2];
  logic [15:0] m_keys [2];

  joycon_poll_sched #(.CLK_FREQ_HZ(1_000_000), .POLL_PERIOD_US(100), .TIMEOUT_US(20), .MISS_LIMIT(3)) u_dut (
    .clk(clk), .rst(rst), .enable(en), .req_L(req_l), .req_R(req_r), .done_L(done_l), .done_R(done_r),
    .keys_L(keys_l), .keys_R(keys_r), .conn_L(conn_l), .conn_R(conn_r), .keys(keys),
    .keys_valid(keys_valid), .busy(busy), .overrun(overrun));

  joycon_poll_sched #(.CLK_FREQ_HZ(1_000_000), .POLL_PERIOD_US(100), .TIMEOUT_US(1000), .MISS_LIMIT(3)) u_slow (
    .clk(clk), .rst(rst), .enable(s_en), .req_L(s_req_l), .req_R(s_req_r), .done_L(s_done_l), .done_R(s_done_r),
    .keys_L(s_keys_l), .keys_R(s_keys_r), .conn_L(s_conn_l), .conn_R(s_conn_r), .keys(s_keys),
    .keys_valid(s_keys_valid), .busy(s_busy), .overrun(s_overrun));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [21:0] exp_merge(input logic [15:0] l, input logic [15:0] r);
    return {l[13], r[12], l[11], r[10], r[9], l[8], l[7:0], r[7:0]};
  endfunction

  function automatic int exp_gap(input int d);
    return (d >= 1 && d <= TO) ? d + 1 : TO + 1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_miss[s] = 0;
      m_conn[s] = 1'b0;
      m_keys[s] = 16'h0000;
    end
  endtask

  task automatic model_side(input int s, input int d, input logic [15:0] k);
    if (d >= 1 && d <= TO) begin
      m_keys[s] = k;
      m_miss[s] = 0;
      m_conn[s] = 1'b1;
    end else begin
      if (m_miss[s] < LIMIT) m_miss[s]++;
      if (m_miss[s] == LIMIT) begin
        m_conn[s] = 1'b0;
        m_keys[s] = 16'h0000;
      end
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_req_l"}, req_l, 0);
    check_val({pfx, "_req_r"}, req_r, 0);
    check_val({pfx, "_conn_l"}, conn_l, 0);
    check_val({pfx, "_conn_r"}, conn_r, 0);
    check_val({pfx, "_keys"}, keys, 0);
    check_val({pfx, "_keys_valid"}, keys_valid, 0);
    check_val({pfx, "_busy"}, busy, 0);
    check_val({pfx, "_overrun"}, overrun, 0);
  endtask

`ifdef JOYCON_REPROBE_THROTTLE_EN
  task automatic throttle_test();
    for (int r = 0; r < 17; r++) begin
      bit got_l, got_v;
      int rcnt;
      got_l = 1'b0;
      got_v = 1'b0;
      rcnt  = -1;
      for (int i = 0; i < 300 && !got_v; i++) begin
        step();
        if (req_l) got_l = 1'b1;
        if (req_r) rcnt = 0;
        else if (rcnt >= 0) rcnt++;
        done_r = (rcnt == 5);
        keys_r = 16'h00A5;
        if (keys_valid) got_v = 1'b1;
      end
      check_val($sformatf("thr_req_l_round%0d", r), got_l, (r % 8 == 0) ? 1 : 0);
      check_val($sformatf("thr_round_end%0d", r), got_v, 1);
    end
  endtask
`else
  // mode 0: plain round, 1: drop enable during WAIT_L, 2: reset during WAIT_R
  task automatic run_round(input int dl, input int dr, input logic [15:0] kl, input logic [15:0] kr,
                           input int mode);
    int tl, tr, tv, extra, n_kv;
    bit seen;
    seen = 1'b0; extra = 0; tl = 0; tr = 0; tv = 0; n_kv = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      seen   = req_l;
      done_l = ($urandom_range(0, 3) == 0);
      keys_l = 16'($urandom);
      done_r = ($urandom_range(0, 3) == 0);
      keys_r = 16'($urandom);
    end
    if (!seen) begin
      check_val("req_l_seen", 0, 1);
      return;
    end
    tl = cyc;
    check_val("round_start", tl, exp_tl);
    exp_tl = tl + 100;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      if (req_r) begin
        seen = 1'b1;
        tr   = cyc;
      end else begin
        if (req_l) extra++;
        if (mode == 1 && c == 1) en = 1'b0;
        done_l = (c == dl);
        keys_l = (c == dl) ? kl : 16'($urandom);
        done_r = ($urandom_range(0, 1) == 1);
        keys_r = 16'($urandom);
      end
    end
    if (!seen) begin
      check_val("req_r_seen", 0, 1);
      return;
    end
    check_val("gap_l", tr - tl, exp_gap(dl));
    model_side(0, dl, kl);
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      if (keys_valid) begin
        seen = 1'b1;
        tv   = cyc;
      end else begin
        if (req_l || req_r) extra++;
        if (mode == 2 && c == 3) begin
          rst = 1'b1; done_l = 1'b0; done_r = 1'b0;
          step();
          check_reset_outputs("midrst");
          rst = 1'b0;
          model_reset();
          exp_tl = cyc + 101;
          for (int k = 0; k < 40; k++) begin
            step();
            if (keys_valid) n_kv++;
          end
          check_val("midrst_no_keys_valid", n_kv, 0);
          return;
        end
        done_r = (c == dr);
        keys_r = (c == dr) ? kr : 16'($urandom);
        done_l = ($urandom_range(0, 1) == 1);
        keys_l = 16'($urandom);
      end
    end
    if (!seen) begin
      check_val("keys_valid_seen", 0, 1);
      return;
    end
    check_val("gap_r", tv - tr, exp_gap(dr));
    model_side(1, dr, kr);
    check_val("keys", keys, exp_merge(m_keys[0], m_keys[1]));
    check_val("conn_l", conn_l, m_conn[0]);
    check_val("conn_r", conn_r, m_conn[1]);
    check_val("busy_in_done", busy, 1);
    check_val("extra_req", extra, 0);
    step();
    done_l = 1'b0; done_r = 1'b0;
    check_val("keys_valid_pulse", keys_valid, 0);
    check_val("busy_after", busy, 0);
    if (mode == 1) begin
      extra = 0;
      for (int k = 0; k < 250; k++) begin
        step();
        if (req_l || busy) extra++;
      end
      check_val("disabled_idle", extra, 0);
      en = 1'b1;
      exp_tl = cyc + 101;
    end
  endtask

  task automatic slow_test();
    int ts, tr, tv, n_kv;
    bit seen;
    seen = 1'b0; ts = 0; tr = 0; tv = 0; n_kv = 0;
    step();
    s_en = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      step();
      seen = s_req_l;
    end
    ts = cyc;
    check_val("slow_req_l_seen", seen, 1);
    seen = 1'b0;
    for (int c = 1; c <= 120 && !seen; c++) begin
      step();
      if (s_req_r) begin
        seen = 1'b1;
        tr   = cyc;
      end else begin
        if (c == 50) check_val("slow_overrun_pre", s_overrun, 0);
        s_done_l = (c == 90);
        s_keys_l = 16'h0900;
      end
    end
    check_val("slow_gap_l", tr - ts, 91);
    seen = 1'b0;
    for (int c = 1; c <= 120 && !seen; c++) begin
      step();
      if (s_keys_valid) begin
        seen = 1'b1;
        tv   = cyc;
      end else begin
        s_done_r = (c == 90);
        s_keys_r = 16'h0402;
      end
    end
    check_val("slow_gap_r", tv - tr, 91);
    check_val("slow_keys", s_keys, exp_merge(16'h0900, 16'h0402));
    check_val("slow_overrun_set", s_overrun, 1);
    s_done_l = 1'b0; s_done_r = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (s_keys_valid) n_kv++;
      seen = s_req_l;
    end
    check_val("slow_tick_dropped", cyc - ts, 200);
    check_val("slow_extra_valid", n_kv, 0);
    check_val("slow_overrun_sticky", s_overrun, 1);
    s_en = 1'b0;
  endtask
`endif

  initial begin
    #600_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; done_l = 1'b0; done_r = 1'b0; keys_l = 16'h0; keys_r = 16'h0;
    s_en = 1'b0; s_done_l = 1'b0; s_done_r = 1'b0; s_keys_l = 16'h0; s_keys_r = 16'h0;
    model_reset();
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    en = 1'b1;
    exp_tl = cyc + 101;
`ifdef JOYCON_REPROBE_THROTTLE_EN
    throttle_test();
`else
    run_round(5, 5, 16'h2001, 16'h0208, 0);
    check_val("keys_basic", keys, 22'h220108);
    for (int i = 0; i < 3; i++) begin
      run_round($urandom_range(1, 20), 0, 16'($urandom), 16'($urandom), 0);
      check_val($sformatf("silent_r_conn_r%0d", i), conn_r, (i < 2) ? 1 : 0);
    end
    check_val("silent_r_keys_lo", keys[7:0], 0);
    check_val("silent_r_conn_l", conn_l, 1);
    run_round(20, 20, 16'($urandom), 16'($urandom), 0);
    check_val("same_cycle_conn_l", conn_l, 1);
    run_round(21, 3, 16'($urandom), 16'($urandom), 0);
    for (int i = 0; i < 14; i++) begin
      int dl, dr;
      dl = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
      dr = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
      run_round(dl, dr, 16'($urandom), 16'($urandom), 0);
    end
    run_round($urandom_range(1, 20), $urandom_range(1, 20), 16'($urandom), 16'($urandom), 1);
    run_round($urandom_range(1, 20), $urandom_range(1, 20), 16'($urandom), 16'($urandom), 0);
    run_round(5, 5, 16'($urandom), 16'($urandom), 2);
    run_round(4, 6, 16'($urandom), 16'($urandom), 0);
    check_val("overrun_main", overrun, 0);
    slow_test();
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/joycon_poll_sched.md
JOYCON_POLL_SCHED -- requirements
Module: joycon_poll_sched

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter POLL_PERIOD_US, default 15000, round start period.
REQ-003 SHALL have parameter TIMEOUT_US, default 5000, max wait for one side's response.
REQ-004 SHALL have parameter MISS_LIMIT, default 3, consecutive timeouts before a side is declared disconnected.
REQ-005 SHALL have port clk  input  1  system clock; one clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port enable  input  1  polling enable.
REQ-008 SHALL have ports req_L / req_R  output  1  one-cycle poll request to left/right Joycon engine.
REQ-009 SHALL have ports done_L / done_R  input  1  one-cycle response-valid pulse from left/right engine.
REQ-010 SHALL have ports keys_L / keys_R  input  16  raw button words, sampled on the matching done pulse.
REQ-011 SHALL have ports conn_L / conn_R  output  1  connection state per side.
REQ-012 SHALL have port keys  output  22  merged key word.
REQ-013 SHALL have port keys_valid  output  1  one-cycle pulse when a round completes.
REQ-014 SHALL have ports busy  output  1  round in progress; overrun  output  1  sticky, tick arrived while busy.

Function
REQ-015 SHALL derive PERIOD_CYC = CLK_FREQ_HZ/1_000_000*POLL_PERIOD_US and TIMEOUT_CYC likewise; the tick counter runs only while enable=1 and clears to 0 while enable=0.
REQ-016 SHALL implement FSM IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, DONE; IDLE->REQ_L on tick; REQ_x->WAIT_x after 1 cycle; WAIT_L->REQ_R; WAIT_R->DONE; DONE->IDLE after 1 cycle.
REQ-017 SHALL assert req_x for exactly the single cycle spent in REQ_x.
REQ-018 SHALL start the wait counter at 0 on the cycle after req_x; exit WAIT_x on done_x, or on timeout when the counter reaches TIMEOUT_CYC-1.
REQ-019 SHALL treat done_x and timeout in the same cycle as done.
REQ-020 SHALL ignore done_x outside WAIT_x and done from the non-selected side.
REQ-021 SHALL, on done_x: latch keys_x, clear the side's miss counter and set conn_x=1.
REQ-022 SHALL, on timeout: increment the side's miss counter, saturating at MISS_LIMIT; when it reaches MISS_LIMIT, set conn_x=0 and clear that side's latched keys to 0.
REQ-023 SHALL drive keys as: [21]=L[13]; [20]=R[12]; [19]=L[11]; [18]=R[10]; [17]=R[9]; [16]=L[8]; [15:8]=L[7:0]; [7:0]=R[7:0]; registered, updated in DONE.
REQ-024 SHALL pulse keys_valid in DONE, coincident with the keys update.
REQ-025 SHALL, on a tick while state!=IDLE, drop the tick and set overrun until reset.
REQ-026 SHALL let enable deassertion mid-round finish the round, then remain in IDLE.
REQ-027 SHALL assert busy whenever state!=IDLE.

Reset
REQ-028 SHALL, on rst=1 at a clock edge: state=IDLE; counters=0; req_L=req_R=0; conn_L=conn_R=0; keys=0; keys_valid=0; busy=0; overrun=0; miss counters=0.
REQ-029 SHALL let reset mid-round abort the round immediately with no keys_valid pulse.

Configuration
REQ-030 SHALL honour macro JOYCON_REPROBE_THROTTLE_EN: when defined, a side with conn_x=0 is polled only in every 8th round (3-bit round counter, poll when ==0) and otherwise skipped: REQ_x/WAIT_x bypassed, no req_x, miss unchanged; when undefined, both sides are polled every round.

Structure
REQ-031 SHALL place the FSM state enum, the merged key bit-index constants and the miss-counter width in shared package joycon_pkg.
REQ-032 SHALL factor the period tick into sub-module joycon_tick_gen (enable, single-cycle tick output).

Verification (bench params CLK_FREQ_HZ=1_000_000, POLL_PERIOD_US=100, TIMEOUT_US=20, MISS_LIMIT=3)
REQ-033 SHALL cover: both engines reply 5 cycles after req, keys_L=16'h2001, keys_R=16'h0208 -> req_L then req_R, keys_valid once, keys=22'h220108, conn_L=conn_R=1.
REQ-034 SHALL cover: right engine silent 3 rounds -> req_R each round, WAIT_R exits after 20 cycles, conn_R=0 after 3rd timeout, keys[7:0]=0, left unaffected.
REQ-035 SHALL cover: done_L and timeout in the same cycle -> treated as done, keys_L latched, miss_L=0.
REQ-036 SHALL cover: engine replies 90 cycles late with timeout disabled by a large TIMEOUT_US -> next tick dropped, overrun=1 sticky.
REQ-037 SHALL cover: rst pulsed during WAIT_R -> all outputs at reset values next cycle, no keys_valid.
REQ-038 SHALL cover: with JOYCON_REPROBE_THROTTLE_EN defined and the left side disconnected -> req_L only in rounds 0, 8, 16.
